// File: rtl/ds18b20_pkg.sv
// Shared types and constants for the DS18B20 temperature-to-BCD display path.
package ds18b20_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } ds_state_e;

  // Power-on value the sensor reports before its first real conversion (+85.0 degC)
  localparam logic [15:0] DS_POR_RAW = 16'h0550;
  // Largest positive raw reading accepted (+125.0 degC)
  localparam logic [15:0] DS_MAX_RAW = 16'h07D0;
  // Largest negative magnitude accepted (-55.0 degC)
  localparam logic [15:0] DS_MIN_MAG = 16'h0370;

  localparam int BIN_W      = 11;
  localparam int BCD_DIGITS = 4;

  // Double-dabble correction: a digit of 5 or more gets 3 added so the next shift carries.
  function automatic logic [3:0] nibble_adjust(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

endpackage

// File: rtl/ds18b20_temp_bcd_dabble.sv
// Iterative binary-to-BCD converter: one shift per clock, BIN_W clocks per conversion.
module bcd_dabble #(
  parameter int BIN_W      = 11,
  parameter int BCD_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin,
  output logic [4*BCD_DIGITS-1:0] bcd,
  output logic                    busy,
  output logic                    done
);
  import ds18b20_pkg::nibble_adjust;

  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  logic [4*BCD_DIGITS-1:0] bcd_q;
  logic [4*BCD_DIGITS-1:0] bcd_adj;
  logic [BIN_W-1:0]        bin_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    busy_q;

  // Apply the add-3 correction to every digit before the next shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      bcd_adj[4*i +: 4] = nibble_adjust(bcd_q[4*i +: 4]);
    end
  end

  // Load on start, then shift the binary operand into the BCD register one bit per clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q  <= '0;
      bin_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      bcd_q  <= '0;
      bin_q  <= bin;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      bcd_q <= {bcd_adj[4*BCD_DIGITS-2:0], bin_q[BIN_W-1]};
      bin_q <= {bin_q[BIN_W-2:0], 1'b0};
      if (cnt_q == CNT_W'(BIN_W - 1)) begin
        cnt_q  <= '0;
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bcd  = bcd_q;
  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CNT_W'(BIN_W - 1));

endmodule

// File: rtl/ds18b20_temp_bcd.sv
// Raw DS18B20 reading to sign + 4 BCD digits with leading-zero blanking for the seg7 scanner.
module ds18b20_temp_bcd
  import ds18b20_pkg::*;
#(
  parameter int STABLE_CYC  = 4,
  parameter bit SUPPRESS_85 = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] temperature,
  output logic [15:0] bcd,
  output logic [3:0]  blank,
  output logic        neg,
  output logic        err,
  output logic        bcd_vld,
  output logic        busy
);

  localparam int CNT_W = $clog2(STABLE_CYC + 1);

  ds_state_e state_q, state_d;

  logic [15:0]      prev_temp;
  logic [15:0]      snapshot;
  logic [CNT_W-1:0] stable_cnt;
  logic [CNT_W-1:0] run_len;
  logic             stable_ok;
  logic             accept;
  logic             por_skip;
  logic             seen_valid;

  logic [15:0]      mag;
  logic [6:0]       int_part;
  logic [3:0]       frac;
  logic [3:0]       tenths;
  logic [BIN_W-1:0] load_val;
  logic             range_err;
  logic             sgn_q;
  logic             err_q;

  logic [4*BCD_DIGITS-1:0] dab_bcd;
  logic                    dab_busy;
  logic                    dab_done;

  // Length of the current run of identical samples, including this clock, and accept decision
  always_comb begin
    run_len = CNT_W'(1);
    if (temperature == prev_temp) begin
      run_len = (stable_cnt == CNT_W'(STABLE_CYC)) ? stable_cnt : stable_cnt + CNT_W'(1);
    end
    stable_ok = (run_len == CNT_W'(STABLE_CYC));
    accept    = (state_q == ST_IDLE) && stable_ok && (temperature != snapshot);
    por_skip  = SUPPRESS_85 && !seen_valid && (temperature == DS_POR_RAW);
  end

  // Track the input continuously; capture a stable new value only while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_temp  <= 16'h0000;
      stable_cnt <= '0;
      snapshot   <= 16'h0000;
    end else begin
      prev_temp  <= temperature;
      stable_cnt <= run_len;
      if (accept) begin
        snapshot <= temperature;
      end
    end
  end

  // Sign/magnitude split, tenths rounding-down and range check on the captured sample
  always_comb begin
    mag       = snapshot[15] ? (~snapshot + 16'd1) : snapshot;
    int_part  = mag[10:4];
    frac      = mag[3:0];
    tenths    = 4'(({4'b0000, frac} * 8'd10) >> 4);
    load_val  = BIN_W'(int_part) * BIN_W'(10) + BIN_W'(tenths);
    range_err = !((&snapshot[15:11]) || !(|snapshot[15:11]))
             || (!snapshot[15] && (snapshot > DS_MAX_RAW))
             || ( snapshot[15] && (mag > DS_MIN_MAG));
  end

  bcd_dabble #(
    .BIN_W      (BIN_W),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_dabble (
    .clk   (clk),
    .rst_n (rst_n),
    .start (state_q == ST_LOAD),
    .bin   (load_val),
    .bcd   (dab_bcd),
    .busy  (dab_busy),
    .done  (dab_done)
  );

  // Conversion sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: one LOAD clock, SHIFT until the converter finishes, one DONE clock
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept && !por_skip) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_SHIFT;
      ST_SHIFT: if (dab_done) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Latch sign/range at LOAD, publish the result (or flag the error) at DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd        <= 16'h0000;
      blank      <= 4'b1100;
      neg        <= 1'b0;
      err        <= 1'b0;
      bcd_vld    <= 1'b0;
      seen_valid <= 1'b0;
      sgn_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      bcd_vld <= 1'b0;
      if (state_q == ST_LOAD) begin
        sgn_q <= snapshot[15];
        err_q <= range_err;
      end
      if (state_q == ST_DONE) begin
        bcd_vld <= 1'b1;
        if (err_q) begin
          err <= 1'b1;
        end else begin
          bcd        <= dab_bcd;
          neg        <= sgn_q && (dab_bcd != '0);
          blank      <= {dab_bcd[15:12] == 4'd0,
                         (dab_bcd[15:12] == 4'd0) && (dab_bcd[11:8] == 4'd0),
                         2'b00};
          err        <= 1'b0;
          seen_valid <= 1'b1;
        end
      end
    end
  end

  assign busy = (state_q != ST_IDLE) || dab_busy;

endmodule

// File: tb/tb_ds18b20_temp_bcd.sv
// Directed scoreboard bench for ds18b20_temp_bcd.
module tb_ds18b20_temp_bcd;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  blank;
    logic        neg;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] temperature;
  logic [15:0] bcd;
  logic [3:0]  blank;
  logic        neg;
  logic        err;
  logic        bcd_vld;
  logic        busy;

  exp_t sb[$];
  int   checks;
  int   errors;
  int   vld_count;

  ds18b20_temp_bcd #(
    .STABLE_CYC  (4),
    .SUPPRESS_85 (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .temperature (temperature),
    .bcd         (bcd),
    .blank       (blank),
    .neg         (neg),
    .err         (err),
    .bcd_vld     (bcd_vld),
    .busy        (busy)
  );

  // 50 MHz clock
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard: every bcd_vld pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (bcd_vld === 1'b1) begin
      exp_t e;
      vld_count++;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("[TB] FAIL unexpected_vld: got pulse %0d expected none pending", vld_count);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("bcd",   32'(bcd),   32'(e.bcd));
        check("blank", 32'(blank), 32'(e.blank));
        check("neg",   32'(neg),   32'(e.neg));
        check("err",   32'(err),   32'(e.err));
      end
    end
  end

  // Wait for the next result pulse, checking latency from the drive point and busy mid-way
  task automatic wait_vld(input string tag, input int exp_lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 6) check({tag, "_busy"}, 32'(busy), 32'd1);
    end while (bcd_vld !== 1'b1 && n < 60);
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    repeat (2) @(negedge clk);
  endtask

  task automatic apply_stimulus(input string tag, input logic [15:0] raw,
                                input logic [15:0] e_bcd, input logic [3:0] e_blank,
                                input logic e_neg, input logic e_err);
    exp_t e;
    e.bcd = e_bcd; e.blank = e_blank; e.neg = e_neg; e.err = e_err;
    sb.push_back(e);
    temperature = raw;
    wait_vld(tag, 17);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bcd"},   32'(bcd),     32'h0000);
    check({tag, "_blank"}, 32'(blank),   32'hC);
    check({tag, "_neg"},   32'(neg),     32'd0);
    check({tag, "_err"},   32'(err),     32'd0);
    check({tag, "_vld"},   32'(bcd_vld), 32'd0);
    check({tag, "_busy"},  32'(busy),    32'd0);
  endtask

  initial begin
    int base;
    int n;
    exp_t e;
    checks      = 0;
    errors      = 0;
    vld_count   = 0;
    rst_n       = 1'b0;
    temperature = 16'h0000;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] POR filter");
    base = vld_count;
    temperature = 16'h0550;
    repeat (30) @(negedge clk);
    check("por_no_vld", 32'(vld_count), 32'(base));
    check("por_idle", 32'(busy), 32'd0);
    apply_stimulus("p25",  16'h0190, 16'h0250, 4'b1000, 1'b0, 1'b0);
    apply_stimulus("p85",  16'h0550, 16'h0850, 4'b1000, 1'b0, 1'b0);

    $display("[TB] basic conversions");
    apply_stimulus("p25_06", 16'h0191, 16'h0250, 4'b1000, 1'b0, 1'b0);
    apply_stimulus("m10_1",  16'hFF5E, 16'h0101, 4'b1000, 1'b1, 1'b0);
    apply_stimulus("m0_06",  16'hFFFF, 16'h0000, 4'b1100, 1'b0, 1'b0);

    $display("[TB] limits");
    apply_stimulus("p125",   16'h07D0, 16'h1250, 4'b0000, 1'b0, 1'b0);
    apply_stimulus("m55",    16'hFC90, 16'h0550, 4'b1000, 1'b1, 1'b0);
    apply_stimulus("over",   16'h07D1, 16'h0550, 4'b1000, 1'b1, 1'b1);
    apply_stimulus("zero",   16'h0000, 16'h0000, 4'b1100, 1'b0, 1'b0);

    $display("[TB] glitch filter");
    base = vld_count;
    temperature = 16'h0190;
    repeat (3) @(negedge clk);
    temperature = 16'h0000;
    repeat (30) @(negedge clk);
    check("glitch_no_vld", 32'(vld_count), 32'(base));

    $display("[TB] change while busy");
    base = vld_count;
    e.bcd = 16'h0500; e.blank = 4'b1000; e.neg = 1'b0; e.err = 1'b0;
    sb.push_back(e);
    e.bcd = 16'h0250; e.blank = 4'b1000; e.neg = 1'b1; e.err = 1'b0;
    sb.push_back(e);
    temperature = 16'h0320;
    repeat (8) @(negedge clk);
    temperature = 16'hFE70;
    n = 0;
    while (vld_count < base + 2 && n < 120) begin
      @(negedge clk);
      n++;
    end
    check("busy_change_pulses", 32'(vld_count - base), 32'd2);
    repeat (2) @(negedge clk);

    $display("[TB] reset mid-conversion");
    base = vld_count;
    temperature = 16'h07D0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    repeat (3) @(negedge clk);
    check("mid_reset_no_vld", 32'(vld_count), 32'(base));
    e.bcd = 16'h1250; e.blank = 4'b0000; e.neg = 1'b0; e.err = 1'b0;
    sb.push_back(e);
    rst_n = 1'b1;
    wait_vld("resume", 17);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
